// File: rtl/uart_rx.sv
// uart_rx: async serial receiver (start, 8 data LSB-first, optional parity, stop) with 16x oversampling and 2-of-3 voting.
// Latency: valid rises (9*16+9)*DIV + 3 clocks after the rxd start edge (+16*DIV when parity is enabled).
// Backpressure: single holding register; a frame finishing while valid is pending is dropped and flagged as overrun.
module uart_rx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       sysClk,
    input  logic       sysRstb,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frameErr,
    output logic       parityErr,
    output logic       overrun,
    output logic       busy
);
    // Rounded clocks-per-oversample-tick.
    localparam int DIV = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_s_d;
    logic [DW-1:0] div_cnt;
    logic [3:0]    os_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          s7;
    logic          s8;
    logic          par_bad;

    logic          fall;
    logic          tick;
    logic [3:0]    os_nxt;
    logic          decide;
    logic          bit_end;
    logic          maj;
    logic          hs;

    // os_nxt is the oversample index this tick lands on; index 0 marks the start of the next bit.
    assign fall    = rx_s_d & ~rx_s;
    assign tick    = (state != IDLE) && (div_cnt == DW'(DIV - 1));
    assign os_nxt  = os_cnt + 4'd1;
    assign decide  = tick && (os_nxt == 4'd9);
    assign bit_end = tick && (os_nxt == 4'd0);
    assign maj     = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
    assign hs      = valid & ready;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection; idle-high reset values.
    always_ff @(posedge sysClk or negedge sysRstb) begin
        if (!sysRstb) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // Oversample tick divider, parked at zero while idle so every frame starts phase-aligned.
    always_ff @(posedge sysClk or negedge sysRstb) begin
        if (!sysRstb) begin
            div_cnt <= '0;
        end else if (state == IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Frame FSM: sample voting, bit shifting, delivery into the holding register and consumer handshake.
    always_ff @(posedge sysClk or negedge sysRstb) begin
        if (!sysRstb) begin
            state     <= IDLE;
            os_cnt    <= 4'd0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            s7        <= 1'b0;
            s8        <= 1'b0;
            par_bad   <= 1'b0;
            data      <= 8'h00;
            valid     <= 1'b0;
            frameErr  <= 1'b0;
            parityErr <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // A handshake empties the holding register; a same-cycle delivery below overrides this.
            if (hs) begin
                valid     <= 1'b0;
                frameErr  <= 1'b0;
                parityErr <= 1'b0;
                overrun   <= 1'b0;
            end
            if (tick) begin
                os_cnt <= os_nxt;
                if (os_nxt == 4'd7) s7 <= rx_s;
                if (os_nxt == 4'd8) s8 <= rx_s;
            end
            case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= START;
                        busy    <= 1'b1;
                        os_cnt  <= 4'd0;
                        bit_cnt <= 3'd0;
                        par_bad <= 1'b0;
                    end
                end
                START: begin
                    // A start bit that votes high was a glitch: drop it without delivering anything.
                    if (decide && maj) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (decide) shreg <= {maj, shreg[7:1]};
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (decide) par_bad <= maj ^ (^shreg) ^ (PARITY_ODD != 0);
                    if (bit_end) state <= STOP;
                end
                STOP: begin
                    // Leave at the vote rather than bit end so a back-to-back start edge is not missed.
                    if (decide) begin
                        state <= maj ? IDLE : BREAK;
                        busy  <= ~maj;
                        if (!valid || ready) begin
                            data      <= shreg;
                            frameErr  <= ~maj;
                            parityErr <= par_bad;
                            valid     <= 1'b1;
                            overrun   <= 1'b0;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                BREAK: begin
                    // Hold off until the line recovers so a stuck-low line yields a single frame.
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
